axi_slave_read_port: RTL and testbench
======================================

Name: axi_slave_read_port

Overview:
Parametrised AXI slave read front-end for the AXI2APB bridge. Accepts one AR burst at a time and expands it into per-beat address requests to the bridge engine, with FIXED, INCR and WRAP address generation. Returns engine responses on the R channel with RID, RLAST and RRESP. Rejects illegal bursts locally with SLVERR and never issues engine requests for them.

Parameters:
ADDR_WIDTH, 32, AXI/engine address width
DATA_WIDTH, 32, RDATA width; power of two, 8..1024
ID_WIDTH, 4, ARID/RID width
LEN_WIDTH, 4, ARLEN width (4 = AXI3, 8 = AXI4)
MAX_OUT, 2, maximum issued-but-unanswered engine requests (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  engine allows new bursts
arid  in  ID_WIDTH  read ID
araddr  in  ADDR_WIDTH  start address
arlen  in  LEN_WIDTH  beats-1
arsize  in  3  log2 bytes per beat
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_WIDTH  echoed ARID
rdata  out  DATA_WIDTH  read data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final beat
rvalid  out  1  R valid
rready  in  1  R ready
req_addr  out  ADDR_WIDTH  beat address to engine
req_size  out  3  latched arsize
req_valid  out  1  beat request valid
req_ready  in  1  engine accepts request
rsp_data  in  DATA_WIDTH  engine read data
rsp_err  in  1  engine error (PSLVERR)
rsp_valid  in  1  engine response valid
rsp_ready  out  1  block accepts response
busy  out  1  burst in progress (state != IDLE)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; counters 0; arready, rvalid, rlast, req_valid, rsp_ready, busy = 0; rresp, rdata, rid, req_addr, req_size = 0. Reset mid-burst drops the burst and discards outstanding requests. The engine is reset by the same rst_n.
- States: IDLE, BURST, ERR.
- IDLE: arready = en. AR handshake (arvalid & arready) latches id, addr, len, size and burst. The burst is legal only if all hold: arsize <= log2(DATA_WIDTH/8); arburst != 11; for WRAP, arlen+1 is in {2,4,8,16} and araddr is aligned to 1<<arsize. Legal bursts go to BURST, illegal ones to ERR.
- BURST, request side:
  - req_valid = (req_cnt <= len) & (req_cnt - rsp_cnt < MAX_OUT).
  - First req_valid is asserted in the cycle after the AR handshake, with req_addr = latched araddr.
  - req_cnt increments on req_valid & req_ready.
  - req_valid and req_addr are held stable until accepted.
- Address update after each accepted request, with step = 1<<size:
  - FIXED: address unchanged.
  - INCR: addr + step, ADDR_WIDTH modulo. 4 KB crossing is not checked.
  - WRAP: wrap length W = (len+1)*step, lower boundary = addr & ~(W-1). After the increment, if next addr == boundary + W, it becomes boundary.
- BURST, response side:
  - rsp_ready = ~rvalid | rready (single R output register).
  - On rsp_valid & rsp_ready: rdata = rsp_data, rresp = rsp_err ? 10 : 00, rid = latched id, rlast = (rsp_cnt == len), rvalid = 1; rsp_cnt then increments.
  - rvalid stays 1 and R fields stay stable until rready.
  - R follows response acceptance with 1-cycle latency. Back-to-back beats are supported when rready is held high.
  - An error on one beat does not end the burst early; all len+1 beats are returned.
- ERR: no req_valid and rsp_ready = 0. Emits len+1 beats with rdata = 0, rresp = 10, rid = latched id, rlast on the final beat. The first rvalid is asserted the cycle after the AR handshake.
- Exit: the rvalid & rready & rlast handshake returns the block to IDLE. arready can be high again in the next cycle, giving one idle cycle between bursts.
- Counters are LEN_WIDTH+1 bits, so len = max does not overflow.
- Responses arrive in request order. rsp_valid outside BURST is ignored (rsp_ready = 0).

Test Plan:
- INCR, arlen=3, arsize=2, araddr=0x100, arid=5 -> req_addr 0x100, 0x104, 0x108, 0x10C; 4 R beats with rid=5, rresp=00, rlast only on beat 4; busy drops after the last handshake.
- WRAP, arlen=3, arsize=2, araddr=0x108 -> req_addr 0x108, 0x10C, 0x100, 0x104. FIXED, arlen=2, araddr=0x40 -> three requests at 0x40.
- rready low for 5 cycles mid-burst while rsp_valid is high -> rsp_ready low, rdata/rresp/rlast held stable, no beat lost or duplicated; req_valid stalls once MAX_OUT=2 responses are outstanding.
- Illegal bursts: arburst=11 with arlen=1, and WRAP with arlen=2 -> req_valid never asserted; 2 (resp. 3) beats with rresp=10, rdata=0, rlast on the last beat.
- INCR arlen=2 with rsp_err=1 on beat 2 -> rresp sequence 00, 10, 00; rlast on beat 3.
- rst_n asserted while 2 requests are outstanding in BURST -> all outputs 0 immediately; after release with en=1, arready=1 and a new burst completes normally.

Source files
------------

// File: rtl/axi_slave_read_port_if.sv
// rtl/axi_slave_read_port_if.sv - AR/R channel and engine request/response bundle
// Ports: AR (arid, araddr, arlen, arsize, arburst, arvalid, arready),
//        R (rid, rdata, rresp, rlast, rvalid, rready),
//        engine request (req_addr, req_size, req_valid, req_ready),
//        engine response (rsp_data, rsp_err, rsp_valid, rsp_ready).
// slave modport is the read port's view, master is the AXI master plus engine view.
interface axi_slave_read_port_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int LEN_WIDTH  = 4
);
   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [LEN_WIDTH-1:0]  arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;

   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   logic [ADDR_WIDTH-1:0] req_addr;
   logic [2:0]            req_size;
   logic                  req_valid;
   logic                  req_ready;

   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_err;
   logic                  rsp_valid;
   logic                  rsp_ready;

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      output req_addr, req_size, req_valid,
      input  req_ready,
      input  rsp_data, rsp_err, rsp_valid,
      output rsp_ready
   );

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      input  req_addr, req_size, req_valid,
      output req_ready,
      output rsp_data, rsp_err, rsp_valid,
      input  rsp_ready
   );
endinterface

// File: rtl/axi_slave_read_port.sv
// rtl/axi_slave_read_port.sv - AXI read burst front-end expanding bursts into engine beat requests
// Ports: clk, rst_n (async active-low), en (engine allows new bursts),
//        busy (burst in progress), bus (axi_slave_read_port_if.slave: AR, R,
//        engine request and engine response channels).
module axi_slave_read_port #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int LEN_WIDTH  = 4,
   parameter int MAX_OUT    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   output logic                   busy,
   axi_slave_read_port_if.slave   bus
);
   localparam int CW       = LEN_WIDTH + 1;
   localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

   localparam logic [1:0] B_FIXED = 2'b00;
   localparam logic [1:0] B_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OK  = 2'b00;
   localparam logic [1:0] RESP_SLV = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_ERR} state_t;
   state_t state, state_nxt;

   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic [CW-1:0]         req_cnt;
   logic [CW-1:0]         rsp_cnt;

   logic                  r_valid_q;
   logic [DATA_WIDTH-1:0] r_data_q;
   logic [1:0]            r_resp_q;
   logic                  r_last_q;
   logic [ID_WIDTH-1:0]   r_id_q;

   logic [CW-1:0]         len_ext;
   logic [CW-1:0]         arlen_ext;
   logic [CW-1:0]         outstanding;
   logic                  wrap_len_ok;
   logic                  ar_aligned;
   logic                  ar_legal;
   logic                  ar_fire;
   logic                  req_fire;
   logic                  rsp_fire;
   logic                  r_fire;
   logic                  err_load;
   logic [ADDR_WIDTH-1:0] step;
   logic [ADDR_WIDTH-1:0] incr_addr;
   logic [ADDR_WIDTH-1:0] wrap_bytes;
   logic [ADDR_WIDTH-1:0] wrap_lo;
   logic [ADDR_WIDTH-1:0] next_addr;

   assign len_ext     = {1'b0, len_q};
   assign arlen_ext   = {1'b0, bus.arlen};
   assign outstanding = req_cnt - rsp_cnt;

   // WRAP needs a power-of-two beat count of 2..16 and a size-aligned start.
   assign wrap_len_ok = (arlen_ext == CW'(1)) || (arlen_ext == CW'(3)) ||
                        (arlen_ext == CW'(7)) || (arlen_ext == CW'(15));
   assign ar_aligned  = (bus.araddr & ~({ADDR_WIDTH{1'b1}} << bus.arsize)) == '0;
   assign ar_legal    = (bus.arsize <= 3'(MAX_SIZE)) && (bus.arburst != 2'b11) &&
                        ((bus.arburst != B_WRAP) || (wrap_len_ok && ar_aligned));

   assign ar_fire  = bus.arvalid & bus.arready;
   assign req_fire = bus.req_valid & bus.req_ready;
   assign rsp_fire = bus.rsp_valid & bus.rsp_ready;
   assign r_fire   = r_valid_q & bus.rready;
   // Error bursts synthesise their remaining beats whenever the R register frees up.
   assign err_load = (state == S_ERR) && (!r_valid_q || bus.rready) && (rsp_cnt <= len_ext);

   // Beat address generation for the next accepted request.
   always_comb begin
      step       = ADDR_WIDTH'(1) << size_q;
      incr_addr  = addr_q + step;
      wrap_bytes = ADDR_WIDTH'(len_ext + CW'(1)) << size_q;
      wrap_lo    = addr_q & ~(wrap_bytes - ADDR_WIDTH'(1));
      next_addr  = incr_addr;
      if (burst_q == B_FIXED) begin
         next_addr = addr_q;
      end else if (burst_q == B_WRAP) begin
         if (incr_addr == wrap_lo + wrap_bytes) begin
            next_addr = wrap_lo;
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (ar_fire) begin
               state_nxt = ar_legal ? S_BURST : S_ERR;
            end
         end
         S_BURST, S_ERR: begin
            if (r_fire && r_last_q) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      bus.arready   = 1'b0;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      busy          = 1'b0;
      case (state)
         S_IDLE: begin
            // Gated by rst_n so arready reads 0 while reset is held.
            bus.arready = en & rst_n;
         end
         S_BURST: begin
            busy          = 1'b1;
            bus.req_valid = (req_cnt <= len_ext) && (outstanding < CW'(MAX_OUT));
            bus.rsp_ready = !r_valid_q || bus.rready;
         end
         S_ERR: begin
            busy = 1'b1;
         end
         default: ;
      endcase
   end

   // Burst context, counters and the single R output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         req_cnt   <= '0;
         rsp_cnt   <= '0;
         r_valid_q <= 1'b0;
         r_data_q  <= '0;
         r_resp_q  <= '0;
         r_last_q  <= 1'b0;
         r_id_q    <= '0;
      end else begin
         if (ar_fire) begin
            id_q    <= bus.arid;
            addr_q  <= bus.araddr;
            len_q   <= bus.arlen;
            size_q  <= bus.arsize;
            burst_q <= bus.arburst;
            req_cnt <= '0;
            if (ar_legal) begin
               rsp_cnt <= '0;
            end else begin
               // First error beat is loaded here so rvalid rises right after AR.
               rsp_cnt   <= CW'(1);
               r_valid_q <= 1'b1;
               r_data_q  <= '0;
               r_resp_q  <= RESP_SLV;
               r_id_q    <= bus.arid;
               r_last_q  <= (bus.arlen == '0);
            end
         end
         if (req_fire) begin
            req_cnt <= req_cnt + CW'(1);
            addr_q  <= next_addr;
         end
         if (rsp_fire) begin
            r_valid_q <= 1'b1;
            r_data_q  <= bus.rsp_data;
            r_resp_q  <= bus.rsp_err ? RESP_SLV : RESP_OK;
            r_id_q    <= id_q;
            r_last_q  <= (rsp_cnt == len_ext);
            rsp_cnt   <= rsp_cnt + CW'(1);
         end else if (err_load) begin
            r_valid_q <= 1'b1;
            r_data_q  <= '0;
            r_resp_q  <= RESP_SLV;
            r_id_q    <= id_q;
            r_last_q  <= (rsp_cnt == len_ext);
            rsp_cnt   <= rsp_cnt + CW'(1);
         end else if (r_fire) begin
            r_valid_q <= 1'b0;
         end
      end
   end

   assign bus.rvalid   = r_valid_q;
   assign bus.rdata    = r_data_q;
   assign bus.rresp    = r_resp_q;
   assign bus.rlast    = r_last_q;
   assign bus.rid      = r_id_q;
   assign bus.req_addr = addr_q;
   assign bus.req_size = size_q;
endmodule

// File: tb/tb_axi_slave_read_port.sv
// tb/tb_axi_slave_read_port.sv - scoreboard bench for axi_slave_read_port
module tb_axi_slave_read_port;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 4;
   localparam int LW = 4;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   logic en;
   logic busy;

   always #5 clk = ~clk;

   axi_slave_read_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) bus ();

   axi_slave_read_port #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW), .MAX_OUT(2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .busy  (busy),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [AW-1:0] req_exp[$];
   beat_t         r_exp[$];
   logic [AW-1:0] pending[$];
   logic [AW-1:0] err_addr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
      return {a[15:0] ^ 16'hBEEF, a[15:0]};
   endfunction

   task automatic push_r(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic [1:0] resp, input logic last);
      beat_t b;
      b.id = id; b.data = d; b.resp = resp; b.last = last;
      r_exp.push_back(b);
   endtask

   task automatic expect_beat(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [1:0] resp, input logic last);
      req_exp.push_back(a);
      push_r(id, data_of(a), resp, last);
   endtask

   // Request monitor: every accepted engine request is checked in order.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.req_valid && bus.req_ready) begin
            if (req_exp.size() == 0) begin
               check("req_unexpected", bus.req_valid, 1'b0);
            end else begin
               logic [AW-1:0] e;
               e = req_exp.pop_front();
               check("req_addr", bus.req_addr, e);
               check("req_size", bus.req_size, 3'd2);
            end
         end
      end
   end

   // R monitor: every R handshake is checked against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.rvalid && bus.rready) begin
            if (r_exp.size() == 0) begin
               check("r_unexpected", bus.rvalid, 1'b0);
            end else begin
               beat_t e;
               e = r_exp.pop_front();
               check("rid", bus.rid, e.id);
               check("rdata", bus.rdata, e.data);
               check("rresp", bus.rresp, e.resp);
               check("rlast", bus.rlast, e.last);
            end
         end
      end
   end

   // Engine model: in-order responses, one cycle after each request is accepted.
   initial begin
      logic qh, rh;
      logic [AW-1:0] qa;
      bus.rsp_valid = 1'b0;
      bus.rsp_data  = '0;
      bus.rsp_err   = 1'b0;
      forever begin
         @(negedge clk);
         qh = bus.req_valid & bus.req_ready;
         rh = bus.rsp_valid & bus.rsp_ready;
         qa = bus.req_addr;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            pending.delete();
         end else begin
            if (rh && pending.size() > 0) void'(pending.pop_front());
            if (qh) pending.push_back(qa);
         end
         bus.rsp_valid = (pending.size() > 0);
         if (pending.size() > 0) begin
            bus.rsp_data = data_of(pending[0]);
            bus.rsp_err  = (pending[0] == err_addr);
         end else begin
            bus.rsp_data = '0;
            bus.rsp_err  = 1'b0;
         end
      end
   end

   task automatic issue(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [LW-1:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
      @(posedge clk);
      #1;
      bus.arid = id; bus.araddr = a; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
      bus.arvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.arready) break;
      end
      check("ar_accept", bus.arready, 1'b1);
      @(posedge clk);
      #1;
      bus.arvalid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check({tag, "_busy_drop"}, busy, 1'b0);
      check({tag, "_r_left"}, r_exp.size(), 0);
      check({tag, "_req_left"}, req_exp.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_arready"}, bus.arready, 1'b0);
      check({tag, "_rvalid"}, bus.rvalid, 1'b0);
      check({tag, "_rlast"}, bus.rlast, 1'b0);
      check({tag, "_req_valid"}, bus.req_valid, 1'b0);
      check({tag, "_rsp_ready"}, bus.rsp_ready, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_rresp"}, bus.rresp, 2'b00);
      check({tag, "_rdata"}, bus.rdata, 32'h0);
      check({tag, "_rid"}, bus.rid, 4'h0);
      check({tag, "_req_addr"}, bus.req_addr, 32'h0);
      check({tag, "_req_size"}, bus.req_size, 3'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1;
      en = 1'b1;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
      bus.arvalid = 1'b0;
      bus.rready = 1'b1;
      bus.req_ready = 1'b1;
      err_addr = '1;
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("rst");
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      // en low blocks AR
      @(posedge clk); #1 en = 1'b0;
      @(negedge clk);
      check("en_low_arready", bus.arready, 1'b0);
      @(posedge clk); #1 en = 1'b1;

      // INCR 4 beats
      expect_beat(4'd5, 32'h100, 2'b00, 1'b0);
      expect_beat(4'd5, 32'h104, 2'b00, 1'b0);
      expect_beat(4'd5, 32'h108, 2'b00, 1'b0);
      expect_beat(4'd5, 32'h10C, 2'b00, 1'b1);
      issue(4'd5, 32'h100, 4'd3, 3'd2, 2'b01);
      wait_idle("incr");

      // WRAP 4 beats wrapping at 0x110
      expect_beat(4'd3, 32'h108, 2'b00, 1'b0);
      expect_beat(4'd3, 32'h10C, 2'b00, 1'b0);
      expect_beat(4'd3, 32'h100, 2'b00, 1'b0);
      expect_beat(4'd3, 32'h104, 2'b00, 1'b1);
      issue(4'd3, 32'h108, 4'd3, 3'd2, 2'b10);
      wait_idle("wrap");

      // FIXED 3 beats
      expect_beat(4'd1, 32'h40, 2'b00, 1'b0);
      expect_beat(4'd1, 32'h40, 2'b00, 1'b0);
      expect_beat(4'd1, 32'h40, 2'b00, 1'b1);
      issue(4'd1, 32'h40, 4'd2, 3'd2, 2'b00);
      wait_idle("fixed");

      // rready stall: beat 0 is held, two requests outstanding stall req_valid
      for (int i = 0; i < 8; i++)
         expect_beat(4'd7, 32'h400 + 32'(i * 4), 2'b00, (i == 7));
      issue(4'd7, 32'h400, 4'd7, 3'd2, 2'b01);
      bus.rready = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c >= 3) begin
            check("stall_rvalid", bus.rvalid, 1'b1);
            check("stall_rdata", bus.rdata, data_of(32'h400));
            check("stall_rresp", bus.rresp, 2'b00);
            check("stall_rlast", bus.rlast, 1'b0);
         end
         if (c >= 4) begin
            check("stall_req_valid", bus.req_valid, 1'b0);
            check("stall_rsp_ready", bus.rsp_ready, 1'b0);
         end
      end
      @(posedge clk); #1 bus.rready = 1'b1;
      wait_idle("stall");

      // Illegal burst type
      push_r(4'd9, 32'h0, 2'b10, 1'b0);
      push_r(4'd9, 32'h0, 2'b10, 1'b1);
      issue(4'd9, 32'h80, 4'd1, 3'd2, 2'b11);
      wait_idle("ill_type");

      // Illegal WRAP length
      push_r(4'd10, 32'h0, 2'b10, 1'b0);
      push_r(4'd10, 32'h0, 2'b10, 1'b0);
      push_r(4'd10, 32'h0, 2'b10, 1'b1);
      issue(4'd10, 32'h100, 4'd2, 3'd2, 2'b10);
      wait_idle("ill_wrap");

      // Engine error on beat 2
      err_addr = 32'h204;
      expect_beat(4'd2, 32'h200, 2'b00, 1'b0);
      expect_beat(4'd2, 32'h204, 2'b10, 1'b0);
      expect_beat(4'd2, 32'h208, 2'b00, 1'b1);
      issue(4'd2, 32'h200, 4'd2, 3'd2, 2'b01);
      wait_idle("err_beat");
      err_addr = '1;

      // Reset with two requests outstanding
      req_exp.push_back(32'h300);
      req_exp.push_back(32'h304);
      req_exp.push_back(32'h308);
      issue(4'd6, 32'h300, 4'd7, 3'd2, 2'b01);
      bus.rready = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_req_valid", bus.req_valid, 1'b0);
      check("pre_rst_busy", busy, 1'b1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      check("mid_rst_req_consumed", req_exp.size(), 0);
      req_exp.delete();
      r_exp.delete();
      bus.rready = 1'b1;
      #1 check_reset_outputs("mid_rst");
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_arready", bus.arready, 1'b1);
      expect_beat(4'd4, 32'h500, 2'b00, 1'b0);
      expect_beat(4'd4, 32'h504, 2'b00, 1'b1);
      issue(4'd4, 32'h500, 4'd1, 3'd2, 2'b01);
      wait_idle("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
